ingress_port_writer: RTL and testbench

// - Upstream stage of one switch input port: accepts a 32-bit word stream and frames packets.
// - Each packet is a header word followed by L payload words.
// - Payload words go into that port's input RAM (ADDR_W-bit write port), filled as a ring.
// - For each stored packet, one descriptor {dest, start_addr, len} is queued to the scheduler.
// - Instantiated once per input port (3x) between the Avalon write decode and the input RAMs.

---
 rtl/switch_pkg.sv | 18 +
 rtl/desc_fifo.sv | 47 ++++
 rtl/ingress_port_writer.sv | 171 +++++++++++++++++
 tb/tb_ingress_port_writer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types for the switch ingress path: descriptor layout, header field positions, framer states.
package switch_pkg;

  // Descriptor fields are sized for the widest port; narrower instances zero-extend.
  localparam int DESC_ADDR_W  = 12;
  localparam int DESC_LEN_W   = 8;
  localparam int HDR_DEST_MSB = 31;
  localparam int HDR_DEST_LSB = 30;

  typedef struct packed {
    logic [1:0]             dest;
    logic [DESC_ADDR_W-1:0] start;
    logic [DESC_LEN_W-1:0]  len;
  } desc_t;

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP, COMMIT} st_e;

endpackage

// File: rtl/desc_fifo.sv
// First-word-fall-through FIFO, 1-cycle push-to-valid; simultaneous push/pop when full both occur,
// pop when empty is ignored.
module desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o     = (cnt_q == CNT_FULL);
  assign empty_o    = (cnt_q == '0);
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ingress_port_writer.sv
// Frames header+payload packets into a ring-buffer RAM and queues one descriptor per stored packet;
// descriptor valid 2 cycles after the last payload word. Optional counters under INGRESS_STATS_EN.
module ingress_port_writer
  import switch_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int LEN_W      = 8,
  parameter int DESC_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wr_add,
  output logic [31:0]       ram_wr_data,
  output logic              desc_valid,
  input  logic              desc_ready,
  output desc_t             desc,
  input  logic              rel_valid,
  input  logic [LEN_W-1:0]  rel_len,
  output logic [15:0]       pkt_count,
  output logic [15:0]       drop_count
);

  localparam int CW = ((LEN_W > ADDR_W) ? LEN_W : ADDR_W) + 2;

  st_e               state_q, state_d;
  logic [1:0]        dest_q;
  logic [LEN_W-1:0]  len_q, rem_q;
  logic [ADDR_W-1:0] start_q, wr_ptr_q;
  logic [ADDR_W:0]   used_q, used_d;
  logic              ram_wren_q;
  logic [ADDR_W-1:0] ram_wr_add_q;
  logic [31:0]       ram_wr_data_q;

  logic              fifo_full, fifo_empty;
  logic              xfer, hdr_xfer, pay_wr, desc_push, last_word;
  logic [1:0]        hdr_dest;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_fits;
  logic [CW-1:0]     free_w, used_sum, rel_w;
  desc_t             push_desc;

  assign hdr_dest  = s_data[HDR_DEST_MSB:HDR_DEST_LSB];
  assign hdr_len   = s_data[LEN_W-1:0];
  assign xfer      = s_valid & s_ready;
  assign hdr_xfer  = xfer & (state_q == IDLE);
  assign pay_wr    = xfer & (state_q == PAYLOAD);
  assign desc_push = (state_q == COMMIT);
  assign last_word = (rem_q == LEN_W'(1));

  assign free_w   = (CW'(1) << ADDR_W) - CW'(used_q);
  assign hdr_fits = CW'(hdr_len) <= free_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (xfer && hdr_len != '0)
          state_d = (hdr_dest == 2'd0 || !hdr_fits) ? DROP : PAYLOAD;
      end
      PAYLOAD: if (xfer && last_word) state_d = COMMIT;
      DROP:    if (xfer && last_word) state_d = IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Held low while reset is asserted so no word is taken during reset.
  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      IDLE:          s_ready = ~fifo_full;
      PAYLOAD, DROP: s_ready = 1'b1;
      default:       s_ready = 1'b0;
    endcase
    if (reset) s_ready = 1'b0;
  end

  // Occupancy: writes and releases in the same cycle both apply; over-release clamps to empty.
  always_comb begin
    used_sum = CW'(used_q) + CW'(pay_wr);
    rel_w    = rel_valid ? CW'(rel_len) : '0;
    used_d   = (rel_w > used_sum) ? '0 : (ADDR_W+1)'(used_sum - rel_w);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_q        <= '0;
      len_q         <= '0;
      rem_q         <= '0;
      start_q       <= '0;
      wr_ptr_q      <= '0;
      used_q        <= '0;
      ram_wren_q    <= 1'b0;
      ram_wr_add_q  <= '0;
      ram_wr_data_q <= '0;
    end else begin
      if (hdr_xfer) begin
        dest_q  <= hdr_dest;
        len_q   <= hdr_len;
        rem_q   <= hdr_len;
        start_q <= wr_ptr_q;
      end else if (xfer) begin
        rem_q <= rem_q - LEN_W'(1);
      end
      ram_wren_q <= pay_wr;
      if (pay_wr) begin
        ram_wr_add_q  <= wr_ptr_q;
        ram_wr_data_q <= s_data;
        wr_ptr_q      <= wr_ptr_q + ADDR_W'(1);
      end
      used_q <= used_d;
    end
  end

  assign ram_wren    = ram_wren_q;
  assign ram_wr_add  = ram_wr_add_q;
  assign ram_wr_data = ram_wr_data_q;

  assign push_desc = '{dest:  dest_q,
                       start: DESC_ADDR_W'(start_q),
                       len:   DESC_LEN_W'(len_q)};

  desc_fifo #(
    .DEPTH (DESC_DEPTH),
    .W     ($bits(desc_t))
  ) u_desc_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (desc_push),
    .push_data_i (push_desc),
    .pop_i       (desc_ready),
    .pop_data_o  (desc),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign desc_valid = ~fifo_empty;

`ifdef INGRESS_STATS_EN
  logic        drop_evt;
  logic [15:0] pkt_cnt_q, drop_cnt_q;

  assign drop_evt = hdr_xfer & (hdr_len == '0 || hdr_dest == 2'd0 || !hdr_fits);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (desc_push) pkt_cnt_q  <= pkt_cnt_q + 16'd1;
      if (drop_evt)  drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_ingress_port_writer.sv
// Bench for ingress_port_writer with a 16-word ring: scoreboard queues for RAM writes and descriptors.
module tb_ingress_port_writer;
  import switch_pkg::*;

  localparam int AW = 4;
  localparam int LW = 8;
`ifdef INGRESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, s_valid, s_ready, ram_wren, desc_valid, desc_ready, rel_valid;
  logic [31:0]   s_data, ram_wr_data;
  logic [AW-1:0] ram_wr_add;
  desc_t         desc;
  logic [LW-1:0] rel_len;
  logic [15:0]   pkt_count, drop_count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t   exp_wr[$];
  desc_t exp_desc[$];
  int    cmps = 0, fails = 0;
  int    m_wr = 0, m_used = 0, m_pkts = 0, m_drops = 0;

  ingress_port_writer #(.ADDR_W(AW), .LEN_W(LW), .DESC_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ram_wren(ram_wren), .ram_wr_add(ram_wr_add), .ram_wr_data(ram_wr_data),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc(desc),
    .rel_valid(rel_valid), .rel_len(rel_len), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every RAM write and every popped descriptor is matched against the queues.
  always @(negedge clk) begin : mon
    wr_t   ew;
    desc_t ed;
    if (ram_wren === 1'b1) begin
      cmps++;
      if (exp_wr.size() == 0) begin
        fails++;
        $display("FAIL ram_write_unexpected: got add=%0d data=%h, required no write", ram_wr_add, ram_wr_data);
      end else begin
        ew = exp_wr.pop_front();
        if ({ram_wr_add, ram_wr_data} !== ew) begin
          fails++;
          $display("FAIL ram_write: got add=%0d data=%h, required add=%0d data=%h", ram_wr_add, ram_wr_data, ew.a, ew.d);
        end
      end
    end
    if (desc_valid === 1'b1 && desc_ready === 1'b1) begin
      cmps++;
      if (exp_desc.size() == 0) begin
        fails++;
        $display("FAIL desc_unexpected: got %h, required none", desc);
      end else begin
        ed = exp_desc.pop_front();
        if (desc !== ed) begin
          fails++;
          $display("FAIL desc: got dest=%0d start=%0d len=%0d, required dest=%0d start=%0d len=%0d", desc.dest, desc.start, desc.len, ed.dest, ed.start, ed.len);
        end
      end
    end
  end

  task automatic send(input logic [31:0] w);
    int n = 0;
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      cmps++;
      fails++;
      $display("FAIL send_timeout: s_ready=%b after 50 cycles, required 1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic pkt(input logic [1:0] dest, input int len, input logic [31:0] seed, input bit store);
    if (store) begin
      exp_desc.push_back('{dest: dest, start: DESC_ADDR_W'(m_wr), len: DESC_LEN_W'(len)});
      m_pkts++;
    end else begin
      m_drops++;
    end
    send({dest, 22'd0, 8'(len)});
    for (int i = 0; i < len; i++) begin
      if (store) begin
        exp_wr.push_back('{a: AW'(m_wr), d: seed + 32'(i)});
        m_wr = (m_wr + 1) % (1 << AW);
        m_used++;
      end
      send(seed + 32'(i));
    end
  endtask

  task automatic release_words(input int n);
    rel_valid = 1'b1;
    rel_len   = LW'(n);
    @(posedge clk);
    #1;
    rel_valid = 1'b0;
    m_used    = (n > m_used) ? 0 : m_used - n;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; desc_ready = 1'b1; rel_valid = 1'b0; rel_len = '0;
    repeat (2) @(negedge clk);
    cmps++;
    if ({s_ready, ram_wren, ram_wr_add, ram_wr_data, desc_valid, desc, pkt_count, drop_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got s_ready=%b wren=%b desc_valid=%b desc=%h pkt=%0d drop=%0d, required all 0", s_ready, ram_wren, desc_valid, desc, pkt_count, drop_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    cmps++;
    if (s_ready !== 1'b1 || dut.used_q !== '0) begin
      fails++;
      $display("FAIL reset_release: got s_ready=%b used=%0d, required 1 and 0", s_ready, dut.used_q);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    pkt(2'd1, 3, 32'hA000_0000, 1'b1);
    @(negedge clk);
    cmps++;
    if (ram_wren !== 1'b1 || desc_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_n1: got wren=%b desc_valid=%b, required 1 and 0", ram_wren, desc_valid);
    end
    @(negedge clk);
    cmps++;
    if (desc_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_n2: got desc_valid=%b, required 1", desc_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len();
    pkt(2'd2, 0, 32'h0, 1'b0);
    @(negedge clk);
    cmps++;
    if (s_ready !== 1'b1 || desc_valid !== 1'b0 || drop_count !== (STATS ? 16'(m_drops) : 16'd0)) begin
      fails++;
      $display("FAIL zero_len: got s_ready=%b desc_valid=%b drop=%0d, required 1 0 %0d", s_ready, desc_valid, drop_count, STATS ? m_drops : 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_drop();
    pkt(2'd3, 11, 32'hB000_0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    cmps++;
    if (dut.used_q !== 5'(m_used)) begin
      fails++;
      $display("FAIL drop_fill_used: got %0d, required %0d", dut.used_q, m_used);
    end
    pkt(2'd1, 3, 32'hD000_0000, 1'b0);
    repeat (3) @(negedge clk);
    cmps++;
    if (dut.used_q !== 5'(m_used) || desc_valid !== 1'b0 || drop_count !== (STATS ? 16'(m_drops) : 16'd0)) begin
      fails++;
      $display("FAIL drop_no_store: got used=%0d desc_valid=%b drop=%0d, required %0d 0 %0d", dut.used_q, desc_valid, drop_count, m_used, STATS ? m_drops : 0);
    end
    @(posedge clk); #1;
    release_words(14);
    @(negedge clk);
    cmps++;
    if (dut.used_q !== 5'(m_used)) begin
      fails++;
      $display("FAIL drop_release: got used=%0d, required %0d", dut.used_q, m_used);
    end
    @(posedge clk); #1;
    pkt(2'd2, 3, 32'hC000_0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_fifo_full();
    desc_ready = 1'b0;
    for (int k = 0; k < 4; k++) pkt(2'd1, 1, 32'hE000_0000 + 32'(k * 16), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = {2'd2, 22'd0, 8'd1};
    @(negedge clk);
    cmps++;
    if (s_ready !== 1'b0 || desc_valid !== 1'b1) begin
      fails++;
      $display("FAIL fifo_full_block: got s_ready=%b desc_valid=%b, required 0 and 1", s_ready, desc_valid);
    end
    @(posedge clk); #1;
    desc_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    desc_ready = 1'b0;
    @(negedge clk);
    cmps++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL fifo_pop_unblock: got s_ready=%b, required 1", s_ready);
    end
    exp_desc.push_back('{dest: 2'd2, start: DESC_ADDR_W'(m_wr), len: DESC_LEN_W'(1)});
    m_pkts++;
    @(posedge clk); #1;
    s_valid = 1'b0;
    exp_wr.push_back('{a: AW'(m_wr), d: 32'hF00D_0001});
    m_wr = (m_wr + 1) % (1 << AW);
    m_used++;
    send(32'hF00D_0001);
    desc_ready = 1'b1;
    for (int i = 0; i < 20 && exp_desc.size() != 0; i++) @(negedge clk);
    cmps++;
    if (exp_desc.size() != 0) begin
      fails++;
      $display("FAIL fifo_drain: %0d descriptors still pending, required 0", exp_desc.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rel_simul();
    release_words(m_used);
    exp_desc.push_back('{dest: 2'd1, start: DESC_ADDR_W'(m_wr), len: DESC_LEN_W'(6)});
    m_pkts++;
    send({2'd1, 22'd0, 8'd6});
    for (int i = 0; i < 6; i++) begin
      exp_wr.push_back('{a: AW'(m_wr), d: 32'h5000_0000 + 32'(i)});
      m_wr = (m_wr + 1) % (1 << AW);
      if (i == 5) begin
        rel_valid = 1'b1;
        rel_len   = 8'd2;
      end
      send(32'h5000_0000 + 32'(i));
    end
    rel_valid = 1'b0;
    @(negedge clk);
    cmps++;
    if (dut.used_q !== 5'd4) begin
      fails++;
      $display("FAIL rel_simul: got used=%0d, required 4", dut.used_q);
    end
    m_used = 4;
    @(posedge clk); #1;
    release_words(200);
    @(negedge clk);
    cmps++;
    if (dut.used_q !== 5'd0) begin
      fails++;
      $display("FAIL rel_clamp: got used=%0d, required 0", dut.used_q);
    end
    for (int i = 0; i < 20 && exp_desc.size() != 0; i++) @(negedge clk);
    cmps++;
    if (pkt_count !== (STATS ? 16'(m_pkts) : 16'd0)) begin
      fails++;
      $display("FAIL pkt_count: got %0d, required %0d", pkt_count, STATS ? m_pkts : 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send({2'd1, 22'd0, 8'd5});
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back('{a: AW'(m_wr), d: 32'h7000_0000 + 32'(i)});
      m_wr = (m_wr + 1) % (1 << AW);
      send(32'h7000_0000 + 32'(i));
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    m_wr = 0; m_used = 0; m_pkts = 0; m_drops = 0;
    #1;
    cmps++;
    if ({s_ready, ram_wren, desc_valid, pkt_count, drop_count} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got s_ready=%b wren=%b desc_valid=%b pkt=%0d drop=%0d, required all 0", s_ready, ram_wren, desc_valid, pkt_count, drop_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    release_words(2);
    pkt(2'd3, 2, 32'h9000_0000, 1'b1);
  endtask

  task automatic test_final();
    for (int i = 0; i < 20 && (exp_desc.size() != 0 || exp_wr.size() != 0); i++) @(negedge clk);
    cmps++;
    if (exp_desc.size() != 0 || exp_wr.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d writes %0d descs pending, required 0 and 0", exp_wr.size(), exp_desc.size());
    end
    cmps++;
    if (pkt_count !== (STATS ? 16'(m_pkts) : 16'd0) || drop_count !== (STATS ? 16'(m_drops) : 16'd0) || dut.used_q !== 5'(m_used)) begin
      fails++;
      $display("FAIL final_counts: got pkt=%0d drop=%0d used=%0d, required %0d %0d %0d", pkt_count, drop_count, dut.used_q, STATS ? m_pkts : 0, STATS ? m_drops : 0, m_used);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_drop();
    test_fifo_full();
    test_rel_simul();
    test_reset_mid();
    test_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
